datapath: RTL and testbench
===========================

# datapath

Single-bus 32-bit CPU datapath driven cycle by cycle by an external control unit, or by a bench acting as one. It holds the register file, the special registers, a one-hot-selected shared bus and a combinational ALU. Every transfer is one clock: a source drives the bus, and the selected destinations latch it on the rising edge. It has no output ports; verification observes internal registers hierarchically by the names below.

## Interface
Parameters: none. Ports are listed in positional order; all are inputs.
- clear  in  1  synchronous active-high reset
- clock  in  1  rising-edge clock
- R0in..R15in  in  1 each  load Rn from bus
- R0out..R15out  in  1 each  drive Rn onto bus
- HIin, LOin, HIout, LOout  in  1 each  load/drive HI, LO
- Zhighin, Zlowin, Zhighout, Zlowout  in  1 each  load Z[63:32]/Z[31:0] from ALU; drive either half onto bus
- PCin, PCout  in  1 each  PC load/drive
- MDRin, MDRout, MARin, MARout  in  1 each  MDR/MAR load/drive
- InPortin, InPortout  in  1 each  InPort load (from bus)/drive
- CSEin, CSEout  in  1 each  CSE (constant) register load/drive
- IRin, IRout  in  1 each  IR load/drive
- Mdatain  in  32  memory read data
- MDMuxread  in  1  MDR input select: 1 = Mdatain, 0 = bus
- Yin  in  1  load Y from bus
- ADD, SUB, MUL, DIV, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT, IncPC  in  1 each  ALU operation selects

## Operation
- Registers: R0–R15, HI, LO, PC, MDR, MAR, InPort, CSE, IR and Y are 32 bits. Z is 64 bits.
- Bus: combinational mux, selected by the *out signals.
  - Priority when more than one is asserted: R0..R15, HI, LO, Zhigh, Zlow, PC, MDR, MAR, InPort, CSE, IR.
  - With no out signal asserted, the bus is 0.
- Register loads: each register with its *in asserted loads the bus at the rising edge.
  - Exception: MDR loads Mdatain when MDMuxread=1.
  - Any number of destinations may load in the same cycle.
- ALU: A = Y, B = bus. The ALU produces a 64-bit result C.
  - Zlowin loads C[31:0]; Zhighin loads C[63:32].
- Operation priority when several are asserted: ADD, SUB, MUL, DIV, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT, IncPC. With none asserted, C = 0.
- ADD/SUB: C[31:0] = A±B, wrap-around modulo 2^32; C[63:32] = 0.
- MUL: signed 32×32 → 64-bit product in C.
- DIV: signed; C[31:0] = quotient truncated toward zero; C[63:32] = remainder, which takes the dividend's sign.
  - If B=0: quotient = 0xFFFFFFFF and remainder = A.
- AND/OR: bitwise A and B.
- Shifts and rotates: shift amount n = B[4:0].
  - SHR is logical right, SHRA is arithmetic right, SHL is left.
  - ROR/ROL rotate A by n. n = 0 returns A unchanged.
- NEG: C[31:0] = −B (two's complement). NOT: C[31:0] = ~B.
- IncPC: C[31:0] = B+1, so PCout+IncPC+Zlowin captures PC+1 in Zlow.
- For all 32-bit operations, C[63:32] = 0.

## Timing
- All state changes happen on the rising edge of clock. The bus and ALU are combinational.
- Transfer latency is one cycle: the source is valid on the bus and the destination is updated at the next edge.
- A register may drive the bus and load in the same cycle; it captures the pre-edge bus value, and it is valid for the source and destination to be the same register.
- Reset: clear=1 at a rising edge zeroes every register, including Z, Y and IR.
  - clear takes priority over all *in signals at that edge.
  - Asserting clear mid-sequence discards any in-progress transfer.
- Mdatain must be stable before the edge on which MDRin=1.

## Test plan
- Reset: load nonzero values into R1 and PC, then assert clear for one edge → all registers = 0.
- ROR sequence:
  - Load R2 = 0x000001FF and R3 = 0x00000008 via MDR.
  - Run the fetch: PCout/MARin/IncPC/Zlowin, then Zlowout/PCin/MDRin with Mdatain = 0x40918000, then MDRout/IRin.
  - Then R2out/Yin, R3out/ROR/Zlowin, Zlowout/R1in.
  - Required: R1 = 0xFF000001, PC = 1, IR = 0x40918000.
- MUL: Y = 0xFFFFFFFE (−2), bus = 3, with Zhighin and Zlowin asserted → Z = 0xFFFFFFFF_FFFFFFFA.
- DIV: Y = −7, bus = 2 → Zlow = 0xFFFFFFFD (−3), Zhigh = 0xFFFFFFFF (−1).
  - With bus = 0 → Zlow = 0xFFFFFFFF, Zhigh = −7.
- Shifts: Y = 0x80000010, bus = 4.
  - SHR → 0x08000001.
  - SHRA → 0xF8000001.
  - SHL → 0x00000100.
  - ROL → 0x00000108.
- MDR mux: MDMuxread=0 with R5out asserted (R5 = 0x1234) → MDR = 0x1234.
  - Also check NEG on a bus value of 1 → Zlow = 0xFFFFFFFF.

Source files
------------

// File: rtl/datapath.sv
// Single-bus 32-bit CPU datapath: register file, special registers, shared bus, 64-bit-result ALU.
// Latency: one clock per transfer; bus and ALU are combinational, destinations update on the next edge.
// Backpressure: none; the control unit sequences every cycle and every transfer completes in one clock.
module datapath (
  input  logic        clear,
  input  logic        clock,
  input  logic        R0in,
  input  logic        R1in,
  input  logic        R2in,
  input  logic        R3in,
  input  logic        R4in,
  input  logic        R5in,
  input  logic        R6in,
  input  logic        R7in,
  input  logic        R8in,
  input  logic        R9in,
  input  logic        R10in,
  input  logic        R11in,
  input  logic        R12in,
  input  logic        R13in,
  input  logic        R14in,
  input  logic        R15in,
  input  logic        R0out,
  input  logic        R1out,
  input  logic        R2out,
  input  logic        R3out,
  input  logic        R4out,
  input  logic        R5out,
  input  logic        R6out,
  input  logic        R7out,
  input  logic        R8out,
  input  logic        R9out,
  input  logic        R10out,
  input  logic        R11out,
  input  logic        R12out,
  input  logic        R13out,
  input  logic        R14out,
  input  logic        R15out,
  input  logic        HIin,
  input  logic        LOin,
  input  logic        HIout,
  input  logic        LOout,
  input  logic        Zhighin,
  input  logic        Zlowin,
  input  logic        Zhighout,
  input  logic        Zlowout,
  input  logic        PCin,
  input  logic        PCout,
  input  logic        MDRin,
  input  logic        MDRout,
  input  logic        MARin,
  input  logic        MARout,
  input  logic        InPortin,
  input  logic        InPortout,
  input  logic        CSEin,
  input  logic        CSEout,
  input  logic        IRin,
  input  logic        IRout,
  input  logic [31:0] Mdatain,
  input  logic        MDMuxread,
  input  logic        Yin,
  input  logic        ADD,
  input  logic        SUB,
  input  logic        MUL,
  input  logic        DIV,
  input  logic        AND,
  input  logic        OR,
  input  logic        SHR,
  input  logic        SHRA,
  input  logic        SHL,
  input  logic        ROR,
  input  logic        ROL,
  input  logic        NEG,
  input  logic        NOT,
  input  logic        IncPC
);

  // Z is held as two named halves so the split loads read naturally.
  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } z_t;

  // Architectural state, observed hierarchically by name.
  logic [31:0] R [16];
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] PC;
  logic [31:0] MDR;
  logic [31:0] MAR;
  logic [31:0] InPort;
  logic [31:0] CSE;
  logic [31:0] IR;
  logic [31:0] Y;
  z_t          Z;

  // Shared bus and ALU result.
  logic [31:0] bus;
  z_t          alu_c;

  // Gathered per-register strobes so the file can be handled with loops.
  logic [15:0] r_in;
  logic [15:0] r_out;

  assign r_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                  R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};
  assign r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                  R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};

  // ALU intermediates.
  logic signed [63:0] a_ext;
  logic signed [63:0] b_ext;
  logic signed [63:0] div_den;
  logic signed [63:0] prod;
  logic        [31:0] quot;
  logic        [31:0] rem;
  logic        [4:0]  sh_n;
  logic        [31:0] ror_v;
  logic        [31:0] rol_v;

  // Bus mux: assignments run lowest priority first so the last match (R0 highest) wins; idle bus is 0.
  always_comb begin
    bus = 32'h0;
    if (IRout)     bus = IR;
    if (CSEout)    bus = CSE;
    if (InPortout) bus = InPort;
    if (MARout)    bus = MAR;
    if (MDRout)    bus = MDR;
    if (PCout)     bus = PC;
    if (Zlowout)   bus = Z.lo;
    if (Zhighout)  bus = Z.hi;
    if (LOout)     bus = LO;
    if (HIout)     bus = HI;
    for (int i = 15; i >= 0; i--) begin
      if (r_out[i]) bus = R[i];
    end
  end

  // ALU: A is Y, B is the bus; first asserted operation in priority order selects the result.
  always_comb begin
    a_ext   = {{32{Y[31]}}, Y};
    b_ext   = {{32{bus[31]}}, bus};
    prod    = a_ext * b_ext;
    // Divide in 64 bits so the most-negative / -1 case cannot overflow; a zero divisor is special-cased below.
    div_den = (bus == 32'h0) ? 64'sd1 : b_ext;
    quot    = 32'(a_ext / div_den);
    rem     = 32'(a_ext % div_den);
    sh_n    = bus[4:0];
    // Rotations come from shifting a doubled copy of A; n = 0 leaves A unchanged.
    ror_v   = 32'({Y, Y} >> sh_n);
    rol_v   = 32'(({Y, Y} << sh_n) >> 32);

    alu_c = '0;
    if (ADD)        alu_c = {32'h0, Y + bus};
    else if (SUB)   alu_c = {32'h0, Y - bus};
    else if (MUL)   alu_c = prod;
    else if (DIV) begin
      if (bus == 32'h0) alu_c = {Y, 32'hFFFF_FFFF};
      else              alu_c = {rem, quot};
    end
    else if (AND)   alu_c = {32'h0, Y & bus};
    else if (OR)    alu_c = {32'h0, Y | bus};
    else if (SHR)   alu_c = {32'h0, Y >> sh_n};
    else if (SHRA)  alu_c = {32'h0, 32'($signed(Y) >>> sh_n)};
    else if (SHL)   alu_c = {32'h0, Y << sh_n};
    else if (ROR)   alu_c = {32'h0, ror_v};
    else if (ROL)   alu_c = {32'h0, rol_v};
    else if (NEG)   alu_c = {32'h0, 32'h0 - bus};
    else if (NOT)   alu_c = {32'h0, ~bus};
    else if (IncPC) alu_c = {32'h0, bus + 32'h1};
  end

  // General register file: clear wins, otherwise each selected register latches the bus.
  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < 16; i++) R[i] <= 32'h0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (r_in[i]) R[i] <= bus;
      end
    end
  end

  // Special registers: bus loads, MDR input mux, and split Z loads from the ALU.
  always_ff @(posedge clock) begin
    if (clear) begin
      HI     <= 32'h0;
      LO     <= 32'h0;
      PC     <= 32'h0;
      MDR    <= 32'h0;
      MAR    <= 32'h0;
      InPort <= 32'h0;
      CSE    <= 32'h0;
      IR     <= 32'h0;
      Y      <= 32'h0;
      Z      <= '0;
    end else begin
      if (HIin)     HI     <= bus;
      if (LOin)     LO     <= bus;
      if (PCin)     PC     <= bus;
      if (MDRin)    MDR    <= MDMuxread ? Mdatain : bus;
      if (MARin)    MAR    <= bus;
      if (InPortin) InPort <= bus;
      if (CSEin)    CSE    <= bus;
      if (IRin)     IR     <= bus;
      if (Yin)      Y      <= bus;
      if (Zhighin)  Z.hi   <= alu_c.hi;
      if (Zlowin)   Z.lo   <= alu_c.lo;
    end
  end

endmodule

// File: tb/tb_datapath.sv
// Bench for the single-bus datapath: directed scenarios plus randomized micro-op sequences.
// Latency: each micro-op is applied after an edge and its effect observed 1 time unit after the next edge.
// Backpressure: none; the bench acts as the control unit and drives every cycle.
module tb_datapath;

  localparam int OP_ADD = 0, OP_SUB = 1, OP_MUL = 2, OP_DIV = 3, OP_AND = 4, OP_OR = 5,
                 OP_SHR = 6, OP_SHRA = 7, OP_SHL = 8, OP_ROR = 9, OP_ROL = 10,
                 OP_NEG = 11, OP_NOT = 12, OP_INC = 13;

  logic        clock = 1'b0;
  logic        clear;
  logic [15:0] rin, rout;
  logic        HIin, LOin, HIout, LOout, Zhighin, Zlowin, Zhighout, Zlowout;
  logic        PCin, PCout, MDRin, MDRout, MARin, MARout, InPortin, InPortout;
  logic        CSEin, CSEout, IRin, IRout, MDMuxread, Yin;
  logic [31:0] Mdatain;
  logic [13:0] op;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [31:0] m_r [16];
  logic [31:0] m_hi, m_lo, m_pc, m_mdr, m_mar, m_inp, m_cse, m_ir, m_y;
  logic [63:0] m_z;

  logic [63:0] got [26];
  logic [63:0] exp_v [26];

  datapath dut (
    .clear(clear), .clock(clock),
    .R0in(rin[0]), .R1in(rin[1]), .R2in(rin[2]), .R3in(rin[3]),
    .R4in(rin[4]), .R5in(rin[5]), .R6in(rin[6]), .R7in(rin[7]),
    .R8in(rin[8]), .R9in(rin[9]), .R10in(rin[10]), .R11in(rin[11]),
    .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
    .R0out(rout[0]), .R1out(rout[1]), .R2out(rout[2]), .R3out(rout[3]),
    .R4out(rout[4]), .R5out(rout[5]), .R6out(rout[6]), .R7out(rout[7]),
    .R8out(rout[8]), .R9out(rout[9]), .R10out(rout[10]), .R11out(rout[11]),
    .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
    .HIin(HIin), .LOin(LOin), .HIout(HIout), .LOout(LOout),
    .Zhighin(Zhighin), .Zlowin(Zlowin), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .PCin(PCin), .PCout(PCout), .MDRin(MDRin), .MDRout(MDRout),
    .MARin(MARin), .MARout(MARout), .InPortin(InPortin), .InPortout(InPortout),
    .CSEin(CSEin), .CSEout(CSEout), .IRin(IRin), .IRout(IRout),
    .Mdatain(Mdatain), .MDMuxread(MDMuxread), .Yin(Yin),
    .ADD(op[OP_ADD]), .SUB(op[OP_SUB]), .MUL(op[OP_MUL]), .DIV(op[OP_DIV]),
    .AND(op[OP_AND]), .OR(op[OP_OR]), .SHR(op[OP_SHR]), .SHRA(op[OP_SHRA]),
    .SHL(op[OP_SHL]), .ROR(op[OP_ROR]), .ROL(op[OP_ROL]), .NEG(op[OP_NEG]),
    .NOT(op[OP_NOT]), .IncPC(op[OP_INC])
  );

  always #5 clock = ~clock;

  task automatic idle();
    clear = 0; rin = '0; rout = '0; op = '0;
    HIin = 0; LOin = 0; HIout = 0; LOout = 0; Zhighin = 0; Zlowin = 0; Zhighout = 0; Zlowout = 0;
    PCin = 0; PCout = 0; MDRin = 0; MDRout = 0; MARin = 0; MARout = 0; InPortin = 0; InPortout = 0;
    CSEin = 0; CSEout = 0; IRin = 0; IRout = 0; MDMuxread = 0; Yin = 0; Mdatain = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic load_mdr(input logic [31:0] v);
    Mdatain = v; MDMuxread = 1; MDRin = 1;
    tick();
  endtask

  task automatic load_r(input int i, input logic [31:0] v);
    load_mdr(v);
    MDRout = 1; rin[i] = 1;
    tick();
  endtask

  task automatic load_y(input logic [31:0] v);
    load_mdr(v);
    MDRout = 1; Yin = 1;
    tick();
  endtask

  task automatic snap();
    for (int i = 0; i < 16; i++) got[i] = {32'h0, dut.R[i]};
    got[16] = {32'h0, dut.HI};  got[17] = {32'h0, dut.LO};   got[18] = {32'h0, dut.PC};
    got[19] = {32'h0, dut.MDR}; got[20] = {32'h0, dut.MAR};  got[21] = {32'h0, dut.InPort};
    got[22] = {32'h0, dut.CSE}; got[23] = {32'h0, dut.IR};   got[24] = {32'h0, dut.Y};
    got[25] = dut.Z;
  endtask

  task automatic model_snap();
    for (int i = 0; i < 16; i++) exp_v[i] = {32'h0, m_r[i]};
    exp_v[16] = {32'h0, m_hi};  exp_v[17] = {32'h0, m_lo};  exp_v[18] = {32'h0, m_pc};
    exp_v[19] = {32'h0, m_mdr}; exp_v[20] = {32'h0, m_mar}; exp_v[21] = {32'h0, m_inp};
    exp_v[22] = {32'h0, m_cse}; exp_v[23] = {32'h0, m_ir};  exp_v[24] = {32'h0, m_y};
    exp_v[25] = m_z;
  endtask

  // Spec-level ALU: the first selected operation in the listed order, computed with plain arithmetic.
  function automatic logic [63:0] alu_ref(input logic [13:0] o, input logic [31:0] a, input logic [31:0] b);
    int sel = -1;
    int n = int'(b[4:0]);
    longint sa = $signed(a);
    longint sb = $signed(b);
    longint q, rm, p;
    logic [31:0] t = a;
    for (int k = 0; k < 14; k++) if (sel < 0 && o[k]) sel = k;
    case (sel)
      OP_ADD:  return {32'h0, a + b};
      OP_SUB:  return {32'h0, a - b};
      OP_MUL:  begin p = sa * sb; return p; end
      OP_DIV:  begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb; rm = sa % sb;
        return {rm[31:0], q[31:0]};
      end
      OP_AND:  return {32'h0, a & b};
      OP_OR:   return {32'h0, a | b};
      OP_SHR:  return {32'h0, a >> n};
      OP_SHRA: begin p = sa >>> n; return {32'h0, p[31:0]}; end
      OP_SHL:  return {32'h0, a << n};
      OP_ROR:  begin for (int k = 0; k < n; k++) t = {t[0], t[31:1]}; return {32'h0, t}; end
      OP_ROL:  begin for (int k = 0; k < n; k++) t = {t[30:0], t[31]}; return {32'h0, t}; end
      OP_NEG:  return {32'h0, 32'h0 - b};
      OP_NOT:  return {32'h0, ~b};
      OP_INC:  return {32'h0, b + 32'h1};
      default: return 64'h0;
    endcase
  endfunction

  function automatic logic [31:0] model_bus();
    for (int i = 0; i < 16; i++) if (rout[i]) return m_r[i];
    if (HIout)     return m_hi;
    if (LOout)     return m_lo;
    if (Zhighout)  return m_z[63:32];
    if (Zlowout)   return m_z[31:0];
    if (PCout)     return m_pc;
    if (MDRout)    return m_mdr;
    if (MARout)    return m_mar;
    if (InPortout) return m_inp;
    if (CSEout)    return m_cse;
    if (IRout)     return m_ir;
    return 32'h0;
  endfunction

  // Advance the model by one edge using the currently driven controls.
  task automatic model_step();
    logic [31:0] b;
    logic [63:0] c;
    b = model_bus();
    c = alu_ref(op, m_y, b);
    if (clear) begin
      for (int i = 0; i < 16; i++) m_r[i] = 0;
      m_hi = 0; m_lo = 0; m_pc = 0; m_mdr = 0; m_mar = 0; m_inp = 0; m_cse = 0; m_ir = 0; m_y = 0; m_z = 0;
    end else begin
      for (int i = 0; i < 16; i++) if (rin[i]) m_r[i] = b;
      if (HIin)     m_hi = b;
      if (LOin)     m_lo = b;
      if (Zhighin)  m_z[63:32] = c[63:32];
      if (Zlowin)   m_z[31:0] = c[31:0];
      if (PCin)     m_pc = b;
      if (MDRin)    m_mdr = MDMuxread ? Mdatain : b;
      if (MARin)    m_mar = b;
      if (InPortin) m_inp = b;
      if (CSEin)    m_cse = b;
      if (IRin)     m_ir = b;
      if (Yin)      m_y = b;
    end
  endtask

  task automatic set_src(input int s);
    if (s < 16) rout[s] = 1;
    else case (s)
      16: HIout = 1;     17: LOout = 1;   18: Zhighout = 1; 19: Zlowout = 1;
      20: PCout = 1;     21: MDRout = 1;  22: MARout = 1;   23: InPortout = 1;
      24: CSEout = 1;    25: IRout = 1;
      default: ;
    endcase
  endtask

  task automatic test_reset();
    clear = 1; tick();
    snap();
    for (int i = 0; i < 26; i++) begin
      checks++;
      if (got[i] !== 64'h0) begin
        errors++; $display("FAIL reset_init reg%0d got %h want 0", i, got[i]);
      end
    end
    load_mdr(32'hA5A5_0001);
    MDRout = 1; rin[1] = 1; PCin = 1; tick();
    checks++;
    if (dut.R[1] !== 32'hA5A5_0001 || dut.PC !== 32'hA5A5_0001) begin
      errors++; $display("FAIL reset_preload R1 %h PC %h want a5a50001", dut.R[1], dut.PC);
    end
    // Clear must override loads happening at the same edge.
    clear = 1; MDRout = 1; rin[1] = 1; PCin = 1; Yin = 1; Zlowin = 1; op[OP_INC] = 1; tick();
    snap();
    for (int i = 0; i < 26; i++) begin
      checks++;
      if (got[i] !== 64'h0) begin
        errors++; $display("FAIL reset_clear reg%0d got %h want 0", i, got[i]);
      end
    end
  endtask

  task automatic test_ror_sequence();
    load_r(2, 32'h0000_01FF);
    load_r(3, 32'h0000_0008);
    PCout = 1; MARin = 1; op[OP_INC] = 1; Zlowin = 1; tick();
    Zlowout = 1; PCin = 1; MDRin = 1; MDMuxread = 1; Mdatain = 32'h4091_8000; tick();
    MDRout = 1; IRin = 1; tick();
    rout[2] = 1; Yin = 1; tick();
    rout[3] = 1; op[OP_ROR] = 1; Zlowin = 1; tick();
    Zlowout = 1; rin[1] = 1; tick();
    checks++;
    if (dut.R[1] !== 32'hFF00_0001) begin errors++; $display("FAIL ror_r1 got %h want ff000001", dut.R[1]); end
    checks++;
    if (dut.PC !== 32'h1) begin errors++; $display("FAIL ror_pc got %h want 00000001", dut.PC); end
    checks++;
    if (dut.IR !== 32'h4091_8000) begin errors++; $display("FAIL ror_ir got %h want 40918000", dut.IR); end
    checks++;
    if (dut.MAR !== 32'h0) begin errors++; $display("FAIL ror_mar got %h want 00000000", dut.MAR); end
  endtask

  task automatic test_mul_div();
    load_y(32'hFFFF_FFFE);
    load_mdr(32'h3);
    MDRout = 1; op[OP_MUL] = 1; Zhighin = 1; Zlowin = 1; tick();
    checks++;
    if (dut.Z !== 64'hFFFF_FFFF_FFFF_FFFA) begin errors++; $display("FAIL mul got %h want fffffffffffffffa", dut.Z); end
    load_y(32'hFFFF_FFF9);
    load_mdr(32'h2);
    MDRout = 1; op[OP_DIV] = 1; Zhighin = 1; Zlowin = 1; tick();
    checks++;
    if (dut.Z.lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_quot got %h want fffffffd", dut.Z.lo); end
    checks++;
    if (dut.Z.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_rem got %h want ffffffff", dut.Z.hi); end
    // No source asserted: the bus is 0, so this divides by zero.
    op[OP_DIV] = 1; Zhighin = 1; Zlowin = 1; tick();
    checks++;
    if (dut.Z.lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_quot got %h want ffffffff", dut.Z.lo); end
    checks++;
    if (dut.Z.hi !== 32'hFFFF_FFF9) begin errors++; $display("FAIL div0_rem got %h want fffffff9", dut.Z.hi); end
  endtask

  task automatic test_shifts();
    logic [31:0] want [4];
    int ops [4];
    want = '{32'h0800_0001, 32'hF800_0001, 32'h0000_0100, 32'h0000_0108};
    ops  = '{OP_SHR, OP_SHRA, OP_SHL, OP_ROL};
    load_y(32'h8000_0010);
    load_mdr(32'h4);
    for (int k = 0; k < 4; k++) begin
      MDRout = 1; op[ops[k]] = 1; Zlowin = 1; Zhighin = 1; tick();
      checks++;
      if (dut.Z !== {32'h0, want[k]}) begin
        errors++; $display("FAIL shift_op%0d got %h want %h", ops[k], dut.Z, {32'h0, want[k]});
      end
    end
  endtask

  task automatic test_mdr_neg();
    load_r(5, 32'h0000_1234);
    load_mdr(32'hDEAD_BEEF);
    rout[5] = 1; MDRin = 1; MDMuxread = 0; Mdatain = 32'hFFFF_FFFF; tick();
    checks++;
    if (dut.MDR !== 32'h0000_1234) begin errors++; $display("FAIL mdr_bus got %h want 00001234", dut.MDR); end
    load_mdr(32'h1);
    MDRout = 1; op[OP_NEG] = 1; Zlowin = 1; Zhighin = 1; tick();
    checks++;
    if (dut.Z !== 64'h0000_0000_FFFF_FFFF) begin errors++; $display("FAIL neg got %h want 00000000ffffffff", dut.Z); end
  endtask

  task automatic test_back_to_back();
    load_r(3, 32'h33);
    load_r(7, 32'h77);
    rout[7] = 1; rout[3] = 1; PCout = 1; Yin = 1; tick();
    checks++;
    if (dut.Y !== 32'h33) begin errors++; $display("FAIL prio_y got %h want 00000033", dut.Y); end
    load_r(4, 32'h5);
    rout[4] = 1; Yin = 1; tick();
    rout[4] = 1; rin[4] = 1; op[OP_ADD] = 1; op[OP_SUB] = 1; Zlowin = 1; tick();
    checks++;
    if (dut.Z.lo !== 32'hA || dut.R[4] !== 32'h5) begin
      errors++; $display("FAIL self_add zlo %h r4 %h want 0000000a 00000005", dut.Z.lo, dut.R[4]);
    end
    Zlowout = 1; rin[4] = 1; tick();
    rout[4] = 1; rin[4] = 1; op[OP_INC] = 1; Zlowin = 1; tick();
    checks++;
    if (dut.R[4] !== 32'hA || dut.Z.lo !== 32'hB) begin
      errors++; $display("FAIL self_inc r4 %h zlo %h want 0000000a 0000000b", dut.R[4], dut.Z.lo);
    end
  endtask

  task automatic test_random();
    int k;
    clear = 1; model_step(); tick();
    for (int c = 0; c < 400; c++) begin
      rin = 16'($urandom & $urandom);
      set_src($urandom_range(0, 26));
      if ($urandom_range(0, 3) == 0) set_src($urandom_range(0, 26));
      HIin = ($urandom_range(0, 3) == 0);     LOin = ($urandom_range(0, 3) == 0);
      Zhighin = ($urandom_range(0, 2) == 0);  Zlowin = ($urandom_range(0, 2) == 0);
      PCin = ($urandom_range(0, 3) == 0);     MDRin = ($urandom_range(0, 2) == 0);
      MARin = ($urandom_range(0, 3) == 0);    InPortin = ($urandom_range(0, 3) == 0);
      CSEin = ($urandom_range(0, 3) == 0);    IRin = ($urandom_range(0, 3) == 0);
      Yin = ($urandom_range(0, 2) == 0);
      k = $urandom_range(0, 15);
      if (k < 14) op[k] = 1;
      if ($urandom_range(0, 4) == 0) begin k = $urandom_range(0, 13); op[k] = 1; end
      Mdatain = $urandom;
      MDMuxread = 1'($urandom_range(0, 1));
      clear = ($urandom_range(0, 39) == 0);
      model_step();
      tick();
      snap();
      model_snap();
      for (int i = 0; i < 26; i++) begin
        checks++;
        if (got[i] !== exp_v[i]) begin
          errors++; $display("FAIL rand cyc%0d reg%0d got %h want %h", c, i, got[i], exp_v[i]);
        end
      end
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_ror_sequence();
    test_mul_div();
    test_shifts();
    test_mdr_neg();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
